pipe_ctrl: RTL and testbench

Pipeline controller for the 3-stage core (IF / ID / EX). Collects the jump request and hold request from the execute stage and a wait request from the memory bus. Drives the PC jump, per-stage hold and per-stage flush controls. Sequences multi-cycle flush windows after taken branches and jumps, defers jumps that arrive during a bus wait, and flags execute stalls that last too long.

---
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the execute stage, memory bus and the pipeline controller.
// The controller is the slave; the pipeline datapath (or a bench) drives the master side.
interface pipe_ctrl_if;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_ex_i;
    logic        hold_bus_i;
    logic        pc_jump_en_o;
    logic [31:0] pc_jump_addr_o;
    logic        hold_pc_o;
    logic        hold_if_id_o;
    logic        hold_id_ex_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        stall_timeout_o;

    modport slave (
        input  jump_en_i, jump_addr_i, hold_flag_ex_i, hold_bus_i,
        output pc_jump_en_o, pc_jump_addr_o, hold_pc_o, hold_if_id_o,
               hold_id_ex_o, flush_if_id_o, flush_id_ex_o, stall_timeout_o
    );

    modport master (
        output jump_en_i, jump_addr_i, hold_flag_ex_i, hold_bus_i,
        input  pc_jump_en_o, pc_jump_addr_o, hold_pc_o, hold_if_id_o,
               hold_id_ex_o, flush_if_id_o, flush_id_ex_o, stall_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the IF/ID/EX core: jump issue with flush windows,
// bus-wait freezing with deferred jumps, and a sticky execute-stall timeout flag.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  ctl
);
    localparam int STALL_W_RAW = $clog2(STALL_TIMEOUT + 1);
    localparam int STALL_W     = (STALL_W_RAW < 1) ? 1 : STALL_W_RAW;
    localparam logic [3:0]         FLUSH_INIT  = 4'(FLUSH_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_MAX   = '1;
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_STALL, S_BUS, S_FLUSH} state_t;

    state_t               r_state,         w_state_next;
    logic [3:0]           r_flush_cnt,     w_flush_cnt_next;
    logic [STALL_W-1:0]   r_stall_cnt,     w_stall_cnt_next;
    logic                 r_pend_valid,    w_pend_valid_next;
    logic [31:0]          r_pend_addr,     w_pend_addr_next;
    logic                 r_stall_timeout, w_stall_timeout_next;

    logic        w_issue;
    logic [31:0] w_issue_addr;
    logic        w_run_stall;
    logic        w_freeze;
    logic        w_hold_pc_only;
    logic        w_flush;

    always_comb begin
        w_state_next         = r_state;
        w_flush_cnt_next     = r_flush_cnt;
        w_stall_cnt_next     = '0;
        w_pend_valid_next    = r_pend_valid;
        w_pend_addr_next     = r_pend_addr;
        w_stall_timeout_next = r_stall_timeout;
        w_issue              = 1'b0;
        w_issue_addr         = 32'h0;
        w_run_stall          = 1'b0;
        w_freeze             = 1'b0;
        w_hold_pc_only       = 1'b0;
        w_flush              = 1'b0;

        case (r_state)
            S_IDLE, S_STALL, S_BUS: begin
                if (ctl.hold_bus_i) begin
                    w_freeze     = 1'b1;
                    w_state_next = S_BUS;
                    // First captured jump wins; later ones during the same wait are dropped.
                    if (ctl.jump_en_i && !r_pend_valid) begin
                        w_pend_valid_next = 1'b1;
                        w_pend_addr_next  = ctl.jump_addr_i;
                    end
                end else if (r_pend_valid) begin
                    w_issue           = 1'b1;
                    w_issue_addr      = r_pend_addr;
                    w_pend_valid_next = 1'b0;
                end else if (ctl.jump_en_i) begin
                    w_issue      = 1'b1;
                    w_issue_addr = ctl.jump_addr_i;
                end else if (ctl.hold_flag_ex_i) begin
                    w_run_stall = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_FLUSH: begin
                w_flush = 1'b1;
                if (ctl.hold_bus_i) begin
                    w_hold_pc_only = 1'b1;
                end else begin
                    w_flush_cnt_next = r_flush_cnt - 4'd1;
                    if (r_flush_cnt == 4'd1) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_issue) begin
            w_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_state_next     = S_FLUSH;
                w_flush_cnt_next = FLUSH_INIT;
            end else begin
                w_state_next = S_IDLE;
            end
        end

        if (w_run_stall) begin
            w_freeze         = 1'b1;
            w_state_next     = S_STALL;
            w_stall_cnt_next = (r_stall_cnt == STALL_MAX) ? r_stall_cnt : r_stall_cnt + 1'b1;
            if ((STALL_TIMEOUT != 0) && (w_stall_cnt_next >= STALL_LIMIT)) begin
                w_stall_timeout_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_flush_cnt     <= 4'd0;
            r_stall_cnt     <= '0;
            r_pend_valid    <= 1'b0;
            r_pend_addr     <= 32'h0;
            r_stall_timeout <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_flush_cnt     <= w_flush_cnt_next;
            r_stall_cnt     <= w_stall_cnt_next;
            r_pend_valid    <= w_pend_valid_next;
            r_pend_addr     <= w_pend_addr_next;
            r_stall_timeout <= w_stall_timeout_next;
        end
    end

    // Outputs are silenced for the whole reset cycle, not just after the edge.
    assign ctl.pc_jump_en_o    = !rst && w_issue;
    assign ctl.pc_jump_addr_o  = rst ? 32'h0 : w_issue_addr;
    assign ctl.hold_pc_o       = !rst && (w_freeze || w_hold_pc_only);
    assign ctl.hold_if_id_o    = !rst && w_freeze;
    assign ctl.hold_id_ex_o    = !rst && w_freeze;
    assign ctl.flush_if_id_o   = !rst && w_flush;
    assign ctl.flush_id_ex_o   = !rst && w_flush;
    assign ctl.stall_timeout_o = !rst && r_stall_timeout;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (FLUSH_CYCLES=1/STALL_TIMEOUT=64 and 3/4) share
// one input stream; each cycle both are compared against a rule-level reference model.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        hold_ex = 1'b0;
    logic        hold_bus = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if ifa ();
    pipe_ctrl_if ifb ();

    assign ifa.jump_en_i      = jump_en;
    assign ifa.jump_addr_i    = jump_addr;
    assign ifa.hold_flag_ex_i = hold_ex;
    assign ifa.hold_bus_i     = hold_bus;
    assign ifb.jump_en_i      = jump_en;
    assign ifb.jump_addr_i    = jump_addr;
    assign ifb.hold_flag_ex_i = hold_ex;
    assign ifb.hold_bus_i     = hold_bus;

    pipe_ctrl #(.FLUSH_CYCLES(1), .STALL_TIMEOUT(64)) dut_a (.clk(clk), .rst(rst), .ctl(ifa.slave));
    pipe_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(4))  dut_b (.clk(clk), .rst(rst), .ctl(ifb.slave));

    logic [38:0] obs_a, obs_b;
    assign obs_a = {ifa.pc_jump_en_o, ifa.pc_jump_addr_o, ifa.hold_pc_o, ifa.hold_if_id_o,
                    ifa.hold_id_ex_o, ifa.flush_if_id_o, ifa.flush_id_ex_o, ifa.stall_timeout_o};
    assign obs_b = {ifb.pc_jump_en_o, ifb.pc_jump_addr_o, ifb.hold_pc_o, ifb.hold_if_id_o,
                    ifb.hold_id_ex_o, ifb.flush_if_id_o, ifb.flush_id_ex_o, ifb.stall_timeout_o};

    // Reference model: remaining flush cycles, one deferred-jump slot, length of the
    // current run of execute holds, and the sticky timeout flag.
    int          m_fc[2]  = '{1, 3};
    int          m_sto[2] = '{64, 4};
    int          m_flush_left[2];
    bit          m_pend_v[2];
    logic [31:0] m_pend_a[2];
    int          m_held[2];
    bit          m_to[2];

    task automatic model_step(input int d, output logic [38:0] e);
        logic        je = 1'b0;
        logic [31:0] ja = 32'h0;
        logic        hp = 1'b0, hf = 1'b0, fl = 1'b0;
        logic        to_out = m_to[d];
        if (rst) begin
            to_out = 1'b0;
            m_flush_left[d] = 0;
            m_pend_v[d] = 1'b0;
            m_pend_a[d] = 32'h0;
            m_held[d] = 0;
            m_to[d] = 1'b0;
        end else if (m_flush_left[d] > 0) begin
            fl = 1'b1;
            m_held[d] = 0;
            if (hold_bus) hp = 1'b1;
            else m_flush_left[d]--;
        end else if (hold_bus) begin
            hp = 1'b1; hf = 1'b1;
            m_held[d] = 0;
            if (jump_en && !m_pend_v[d]) begin
                m_pend_v[d] = 1'b1;
                m_pend_a[d] = jump_addr;
            end
        end else if (m_pend_v[d] || jump_en) begin
            je = 1'b1; fl = 1'b1;
            ja = m_pend_v[d] ? m_pend_a[d] : jump_addr;
            m_pend_v[d] = 1'b0;
            m_flush_left[d] = m_fc[d] - 1;
            m_held[d] = 0;
        end else if (hold_ex) begin
            hp = 1'b1; hf = 1'b1;
            m_held[d]++;
            if (m_sto[d] != 0 && m_held[d] >= m_sto[d]) m_to[d] = 1'b1;
        end else begin
            m_held[d] = 0;
        end
        e = {je, ja, hp, hf, hf, fl, fl, to_out};
    endtask

    task automatic check(input string tag, input logic [38:0] obs, input logic [38:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic j, input logic [31:0] a,
                        input logic h, input logic b);
        logic [38:0] e;
        @(negedge clk);
        rst = r; jump_en = j; jump_addr = a; hold_ex = h; hold_bus = b;
        cyc++;
        #1;
        model_step(0, e);
        check("dut_a outputs", obs_a, e);
        model_step(1, e);
        check("dut_b outputs", obs_b, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b1);
        idle(2);

        // Single-cycle jump; dut_a returns to idle immediately, dut_b flushes 3 cycles.
        step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        n_checks++;
        assert (ifa.pc_jump_addr_o === 32'h100) else begin
            n_fail++;
            $error("FAIL jump_addr_a observed=%h expected=%h", ifa.pc_jump_addr_o, 32'h100);
        end
        idle(3);

        // Jump with a bus wait in the second flush cycle.
        step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(4);

        // Bus wait with two jumps; only the first is kept and issued on release.
        step(1'b0, 1'b1, 32'h300, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h400, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        assert (ifa.pc_jump_addr_o === 32'h300) else begin
            n_fail++;
            $error("FAIL deferred_addr observed=%h expected=%h", ifa.pc_jump_addr_o, 32'h300);
        end
        idle(4);

        // Execute hold: 5 cycles, then 10 cycles (dut_b times out).
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(2);
        n_checks++;
        assert (ifb.stall_timeout_o === 1'b1 && ifa.stall_timeout_o === 1'b0) else begin
            n_fail++;
            $error("FAIL timeout_sticky observed=%b%b expected=01",
                   ifa.stall_timeout_o, ifb.stall_timeout_o);
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1);

        // Jump together with execute hold; then reset in the middle of a flush window.
        step(1'b0, 1'b1, 32'h500, 1'b1, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 32'h600, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 20),
                 $urandom,
                 ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 20));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
